gumnut_mem_arbiter: RTL and testbench

//  Shares one unified single-port memory between the Gumnut instruction-fetch bus and data bus.

---
 rtl/gumnut_arb_pkg.sv | 31 +++
 rtl/gumnut_mem_arbiter_if.sv | 53 +++++
 rtl/gumnut_arb_watchdog.sv | 28 ++
 rtl/gumnut_mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_gumnut_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gumnut_arb_pkg.sv
// Shared types and default widths for the Gumnut unified-memory arbiter.
package gumnut_arb_pkg;

  localparam int GUMNUT_IADDR_W  = 12;
  localparam int GUMNUT_IDATA_W  = 18;
  localparam int GUMNUT_DADDR_W  = 8;
  localparam int GUMNUT_DDATA_W  = 8;
  localparam int GUMNUT_TIMEOUT  = 15;
  localparam int GUMNUT_STAT_W   = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_INST = 2'd1,
    GNT_DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    M_INST = 1'b0,
    M_DATA = 1'b1
  } master_e;

  function automatic master_e other_master(input master_e m);
    return (m == M_INST) ? M_DATA : M_INST;
  endfunction

  function automatic logic [GUMNUT_STAT_W-1:0] sat_inc(input logic [GUMNUT_STAT_W-1:0] v,
                                                      input logic en);
    return (en && (v != {GUMNUT_STAT_W{1'b1}})) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/gumnut_mem_arbiter_if.sv
// Fetch bus, data bus and unified memory bus as seen by the arbiter.
// slave: the arbiter itself; master: the core + memory environment around it.
interface gumnut_mem_arbiter_if #(
  parameter int IADDR_W = 12,
  parameter int IDATA_W = 18,
  parameter int DADDR_W = 8,
  parameter int DDATA_W = 8
);
  logic               inst_cyc_i;
  logic               inst_stb_i;
  logic [IADDR_W-1:0] inst_adr_i;
  logic               inst_ack_o;
  logic [IDATA_W-1:0] inst_dat_o;

  logic               data_cyc_i;
  logic               data_stb_i;
  logic               data_we_i;
  logic [DADDR_W-1:0] data_adr_i;
  logic [DDATA_W-1:0] data_dat_i;
  logic               data_ack_o;
  logic [DDATA_W-1:0] data_dat_o;

  logic               mem_cyc_o;
  logic               mem_stb_o;
  logic               mem_we_o;
  logic [IADDR_W:0]   mem_adr_o;
  logic [DDATA_W-1:0] mem_dat_o;
  logic [IDATA_W-1:0] mem_dat_i;
  logic               mem_ack_i;

  logic               bus_err_o;

  modport slave (
    input  inst_cyc_i, inst_stb_i, inst_adr_i,
    output inst_ack_o, inst_dat_o,
    input  data_cyc_i, data_stb_i, data_we_i, data_adr_i, data_dat_i,
    output data_ack_o, data_dat_o,
    output mem_cyc_o, mem_stb_o, mem_we_o, mem_adr_o, mem_dat_o,
    input  mem_dat_i, mem_ack_i,
    output bus_err_o
  );

  modport master (
    output inst_cyc_i, inst_stb_i, inst_adr_i,
    input  inst_ack_o, inst_dat_o,
    output data_cyc_i, data_stb_i, data_we_i, data_adr_i, data_dat_i,
    input  data_ack_o, data_dat_o,
    input  mem_cyc_o, mem_stb_o, mem_we_o, mem_adr_o, mem_dat_o,
    output mem_dat_i, mem_ack_i,
    input  bus_err_o
  );

endinterface

// File: rtl/gumnut_arb_watchdog.sv
// Granted-cycle counter: expire_o fires combinationally on the TIMEOUT-th enabled cycle.
// clr_i restarts the count; en_i marks a granted cycle that saw no memory ack.
module gumnut_arb_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [7:0] r_cnt;
  logic       w_last;

  // r_cnt holds the stalled cycles already seen, so the current one is r_cnt+1.
  assign w_last   = (r_cnt == 8'(TIMEOUT - 1));
  assign expire_o = en_i & w_last;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_cnt <= 8'd0;
    end else if (en_i && !w_last) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/gumnut_mem_arbiter.sv
// Round-robin arbiter sharing one memory between Gumnut fetch and data buses; grant is registered
// (mem_* one cycle after request), held until ack/abort/watchdog. Optional stats: GUMNUT_ARB_STATS_EN.
module gumnut_mem_arbiter
  import gumnut_arb_pkg::*;
#(
  parameter int IADDR_W = GUMNUT_IADDR_W,
  parameter int IDATA_W = GUMNUT_IDATA_W,
  parameter int DADDR_W = GUMNUT_DADDR_W,
  parameter int DDATA_W = GUMNUT_DDATA_W,
  parameter int TIMEOUT = GUMNUT_TIMEOUT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  gumnut_mem_arbiter_if.slave      bus
`ifdef GUMNUT_ARB_STATS_EN
  ,
  output logic [GUMNUT_STAT_W-1:0] stat_inst_gnt_o,
  output logic [GUMNUT_STAT_W-1:0] stat_data_gnt_o,
  output logic [GUMNUT_STAT_W-1:0] stat_stall_o
`endif
);

  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_GNT_INST = GNT_INST;
  localparam logic [1:0] ST_GNT_DATA = GNT_DATA;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  master_e            r_last_gnt;
  master_e            w_last_nxt;
  logic               r_bus_err;

  logic               w_req_inst;
  logic               w_req_data;
  logic               w_gnt_inst;
  logic               w_gnt_data;
  logic               w_live_inst;
  logic               w_live_data;
  logic               w_live;
  logic               w_wd_clr;
  logic               w_wd_en;
  logic               w_expire;
  logic               w_term;
  logic [IADDR_W-1:0] w_data_adr_ext;

  assign w_req_inst  = bus.inst_cyc_i & bus.inst_stb_i;
  assign w_req_data  = bus.data_cyc_i & bus.data_stb_i;
  assign w_gnt_inst  = (r_state == ST_GNT_INST);
  assign w_gnt_data  = (r_state == ST_GNT_DATA);

  // Dropping cyc_i while granted is an abort: the memory cycle is gated off immediately.
  assign w_live_inst = w_gnt_inst & bus.inst_cyc_i;
  assign w_live_data = w_gnt_data & bus.data_cyc_i;
  assign w_live      = w_live_inst | w_live_data;

  assign w_wd_clr    = (r_state == ST_IDLE);
  assign w_wd_en     = w_live & ~bus.mem_ack_i & ~rst_i;
  assign w_term      = (bus.mem_ack_i | w_expire) & ~rst_i;

  gumnut_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (w_wd_clr),
    .en_i     (w_wd_en),
    .expire_o (w_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last_gnt;
    case (r_state)
      ST_IDLE: begin
        if (w_req_inst && w_req_data) begin
          w_state_nxt = (other_master(r_last_gnt) == M_INST) ? ST_GNT_INST : ST_GNT_DATA;
        end else if (w_req_inst) begin
          w_state_nxt = ST_GNT_INST;
        end else if (w_req_data) begin
          w_state_nxt = ST_GNT_DATA;
        end
      end
      ST_GNT_INST: begin
        if (!bus.inst_cyc_i) begin
          w_state_nxt = ST_IDLE;
        end else if (w_term) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = M_INST;
        end
      end
      ST_GNT_DATA: begin
        if (!bus.data_cyc_i) begin
          w_state_nxt = ST_IDLE;
        end else if (w_term) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = M_DATA;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= M_DATA;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_gnt <= w_last_nxt;
      if (w_expire) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  assign w_data_adr_ext = {{(IADDR_W - DADDR_W){1'b0}}, bus.data_adr_i};

  always_comb begin
    bus.mem_adr_o = '0;
    if (w_gnt_inst) begin
      bus.mem_adr_o = {1'b0, bus.inst_adr_i};
    end else if (w_gnt_data) begin
      bus.mem_adr_o = {1'b1, w_data_adr_ext};
    end
  end

  assign bus.mem_cyc_o  = w_live;
  assign bus.mem_stb_o  = w_live;
  assign bus.mem_we_o   = w_live_data & bus.data_we_i;
  assign bus.mem_dat_o  = w_gnt_data ? bus.data_dat_i : '0;

  // A watchdog termination completes the cycle with zero data.
  assign bus.inst_ack_o = w_live_inst & w_term;
  assign bus.data_ack_o = w_live_data & w_term;
  assign bus.inst_dat_o = (w_gnt_inst & ~w_expire) ? bus.mem_dat_i : {IDATA_W{1'b0}};
  assign bus.data_dat_o = (w_gnt_data & ~w_expire) ? bus.mem_dat_i[DDATA_W-1:0] : '0;
  assign bus.bus_err_o  = r_bus_err;

`ifdef GUMNUT_ARB_STATS_EN
  logic [GUMNUT_STAT_W-1:0] r_stat_inst_gnt;
  logic [GUMNUT_STAT_W-1:0] r_stat_data_gnt;
  logic [GUMNUT_STAT_W-1:0] r_stat_stall;
  logic                     w_new_inst;
  logic                     w_new_data;
  logic                     w_stall;

  assign w_new_inst = (r_state == ST_IDLE) & (w_state_nxt == ST_GNT_INST);
  assign w_new_data = (r_state == ST_IDLE) & (w_state_nxt == ST_GNT_DATA);
  assign w_stall    = (w_gnt_inst & w_req_data) | (w_gnt_data & w_req_inst);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stat_inst_gnt <= '0;
      r_stat_data_gnt <= '0;
      r_stat_stall    <= '0;
    end else begin
      r_stat_inst_gnt <= sat_inc(r_stat_inst_gnt, w_new_inst);
      r_stat_data_gnt <= sat_inc(r_stat_data_gnt, w_new_data);
      r_stat_stall    <= sat_inc(r_stat_stall, w_stall);
    end
  end

  assign stat_inst_gnt_o = r_stat_inst_gnt;
  assign stat_data_gnt_o = r_stat_data_gnt;
  assign stat_stall_o    = r_stat_stall;
`endif

endmodule

// File: tb/tb_gumnut_mem_arbiter.sv
// Directed scenarios then randomized traffic, all checked against a transaction-level model.
module tb_gumnut_mem_arbiter;

  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gumnut_mem_arbiter_if bus ();

`ifdef GUMNUT_ARB_STATS_EN
  logic [15:0] stat_i, stat_d, stat_s;
`endif

  gumnut_mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef GUMNUT_ARB_STATS_EN
    ,
    .stat_inst_gnt_o (stat_i),
    .stat_data_gnt_o (stat_d),
    .stat_stall_o    (stat_s)
`endif
  );

  int errs = 0;
  int checks = 0;

  // Model: owner 0=none 1=inst 2=data; last winner; stalled granted cycles; sticky error.
  int m_own, m_last, m_wait;
  bit m_err;
  int m_sg_i, m_sg_d, m_ss;
  bit prev_ack_i, prev_ack_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_last = 2; m_wait = 0; m_err = 0;
    m_sg_i = 0; m_sg_d = 0; m_ss = 0;
  endtask

  task automatic idle_inputs();
    bus.inst_cyc_i = 0; bus.inst_stb_i = 0; bus.inst_adr_i = '0;
    bus.data_cyc_i = 0; bus.data_stb_i = 0; bus.data_we_i = 0;
    bus.data_adr_i = '0; bus.data_dat_i = '0;
    bus.mem_ack_i = 0; bus.mem_dat_i = '0;
  endtask

  // Compare settled outputs with the model, advance the model, move to next cycle.
  task automatic tick(input string tag);
    bit l_i, l_d, live, to, ai, ad, ri, rd, cx, ox;
    logic [12:0] ea;
    l_i  = (m_own == 1) && bus.inst_cyc_i;
    l_d  = (m_own == 2) && bus.data_cyc_i;
    live = l_i || l_d;
    to   = live && !bus.mem_ack_i && (m_wait + 1 == TIMEOUT) && !rst;
    ai   = l_i && (bus.mem_ack_i || to) && !rst;
    ad   = l_d && (bus.mem_ack_i || to) && !rst;
    chk({tag, ":ctl"}, {bus.mem_cyc_o, bus.mem_stb_o, bus.inst_ack_o, bus.data_ack_o, bus.bus_err_o},
        {live, live, ai, ad, m_err});
    ea = l_i ? {1'b0, bus.inst_adr_i} : 13'h1000 + 13'(bus.data_adr_i);
    if (l_i) chk({tag, ":iadr"}, {bus.mem_we_o, bus.mem_adr_o}, {1'b0, ea});
    if (l_d) chk({tag, ":dmem"}, {bus.mem_we_o, bus.mem_adr_o, bus.mem_dat_o},
                 {bus.data_we_i, ea, bus.data_dat_i});
    if (ai) chk({tag, ":idat"}, bus.inst_dat_o, to ? 18'h0 : bus.mem_dat_i);
    if (ad) chk({tag, ":ddat"}, bus.data_dat_o, to ? 8'h0 : bus.mem_dat_i[7:0]);
`ifdef GUMNUT_ARB_STATS_EN
    chk({tag, ":stats"}, {stat_i, stat_d}, {16'(m_sg_i), 16'(m_sg_d)});
    chk({tag, ":stall"}, stat_s, 16'(m_ss));
`endif
    prev_ack_i = ai;
    prev_ack_d = ad;
    ri = bus.inst_cyc_i && bus.inst_stb_i;
    rd = bus.data_cyc_i && bus.data_stb_i;
    if (rst) begin
      model_reset();
    end else if (m_own == 0) begin
      m_wait = 0;
      if (ri && rd) m_own = (m_last == 2) ? 1 : 2;
      else if (ri) m_own = 1;
      else if (rd) m_own = 2;
      if (m_own == 1) m_sg_i++;
      if (m_own == 2) m_sg_d++;
    end else begin
      cx = (m_own == 1) ? bus.inst_cyc_i : bus.data_cyc_i;
      ox = (m_own == 1) ? rd : ri;
      if (ox && m_ss < 65535) m_ss++;
      if (!cx) begin
        m_own = 0;
      end else if (bus.mem_ack_i || to) begin
        m_last = m_own;
        m_own = 0;
        if (to) m_err = 1;
      end else begin
        m_wait++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag);
    #1;
    tick(tag);
  endtask

  initial begin
    int p;
    rst = 1;
    idle_inputs();
    prev_ack_i = 0;
    prev_ack_d = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    #1;
    chk("rst_outs", {bus.mem_cyc_o, bus.mem_stb_o, bus.mem_we_o, bus.inst_ack_o, bus.data_ack_o, bus.bus_err_o}, 6'b0);
    chk("rst_adr", {bus.mem_adr_o, bus.mem_dat_o}, 21'h0);
    tick("rst");
    rst = 0;

    // 1: single fetch, memory acks two cycles after the strobe
    bus.inst_cyc_i = 1; bus.inst_stb_i = 1; bus.inst_adr_i = 12'h005;
    #1; chk("t1_req_nocyc", bus.mem_cyc_o, 1'b0); tick("t1a");
    #1; chk("t1_adr", bus.mem_adr_o, 13'h0005); chk("t1_stb", bus.mem_stb_o, 1'b1); tick("t1b");
    step("t1c");
    bus.mem_ack_i = 1; bus.mem_dat_i = 18'h0080A;
    #1; chk("t1_ack", {bus.inst_ack_o, bus.data_ack_o}, 2'b10); chk("t1_dat", bus.inst_dat_o, 18'h0080A);
    tick("t1d");
    bus.inst_cyc_i = 0; bus.inst_stb_i = 0; bus.mem_ack_i = 0;
    #1; chk("t1_ack_once", bus.inst_ack_o, 1'b0); tick("t1e");

    // 2: tie right after reset goes to fetch, data follows after one idle cycle
    rst = 1; step("t2_rst"); rst = 0;
    bus.inst_cyc_i = 1; bus.inst_stb_i = 1; bus.inst_adr_i = 12'h123;
    bus.data_cyc_i = 1; bus.data_stb_i = 1; bus.data_adr_i = 8'h3C;
    step("t2a");
    bus.mem_ack_i = 1; bus.mem_dat_i = 18'h2ABCD;
    #1; chk("t2_inst_first", bus.mem_adr_o, 13'h0123); chk("t2_iack", {bus.inst_ack_o, bus.data_ack_o}, 2'b10);
    tick("t2b");
    bus.inst_cyc_i = 0; bus.inst_stb_i = 0; bus.mem_ack_i = 0;
    #1; chk("t2_bubble", bus.mem_cyc_o, 1'b0); tick("t2c");
    #1; chk("t2_data_adr", bus.mem_adr_o, 13'h103C); tick("t2d");
    bus.mem_ack_i = 1; bus.mem_dat_i = 18'h3FF5A;
    #1; chk("t2_dack", bus.data_ack_o, 1'b1); chk("t2_ddat", bus.data_dat_o, 8'h5A); tick("t2e");
    bus.data_cyc_i = 0; bus.data_stb_i = 0; bus.mem_ack_i = 0;
    step("t2f");

    // 3: data write while a fetch waits
    bus.data_cyc_i = 1; bus.data_stb_i = 1; bus.data_we_i = 1; bus.data_adr_i = 8'h10; bus.data_dat_i = 8'hA5;
    step("t3a");
    bus.inst_cyc_i = 1; bus.inst_stb_i = 1; bus.inst_adr_i = 12'h077;
    #1; chk("t3_write", {bus.mem_we_o, bus.mem_adr_o, bus.mem_dat_o}, {1'b1, 13'h1010, 8'hA5}); tick("t3b");
    #1; chk("t3_inst_pend", bus.inst_ack_o, 1'b0); chk("t3_hold_adr", bus.mem_adr_o, 13'h1010); tick("t3c");
    bus.mem_ack_i = 1;
    #1; chk("t3_dack", {bus.inst_ack_o, bus.data_ack_o}, 2'b01); tick("t3d");
    bus.data_cyc_i = 0; bus.data_stb_i = 0; bus.data_we_i = 0; bus.mem_ack_i = 0;
    #1; chk("t3_bubble", bus.mem_cyc_o, 1'b0); tick("t3e");
    bus.mem_ack_i = 1; bus.mem_dat_i = 18'h00111;
    #1; chk("t3_inst_gnt", {bus.mem_adr_o, bus.inst_ack_o}, {13'h0077, 1'b1}); tick("t3f");
    bus.inst_cyc_i = 0; bus.inst_stb_i = 0; bus.mem_ack_i = 0;
    step("t3g");

    // 4: memory never acks, watchdog completes on the TIMEOUT-th granted cycle
    bus.inst_cyc_i = 1; bus.inst_stb_i = 1; bus.inst_adr_i = 12'h3FF; bus.mem_dat_i = 18'h3FFFF;
    step("t4_req");
    for (int k = 1; k < TIMEOUT; k++) begin
      #1; chk("t4_wait", bus.inst_ack_o, 1'b0); tick("t4_g");
    end
    #1; chk("t4_to_ack", bus.inst_ack_o, 1'b1); chk("t4_to_dat", bus.inst_dat_o, 18'h0); tick("t4_to");
    bus.inst_cyc_i = 0; bus.inst_stb_i = 0;
    for (int k = 0; k < 4; k++) begin
      #1; chk("t4_err_sticky", bus.bus_err_o, 1'b1); tick("t4_err");
    end

    // 5: reset in the middle of a grant
    bus.inst_cyc_i = 1; bus.inst_stb_i = 1; bus.inst_adr_i = 12'h0AA;
    step("t5a");
    step("t5b");
    rst = 1; bus.mem_ack_i = 1;
    #1; chk("t5_rst_noack", bus.inst_ack_o, 1'b0); tick("t5c");
    rst = 0; bus.mem_ack_i = 0; bus.data_cyc_i = 1; bus.data_stb_i = 1; bus.data_adr_i = 8'hE1;
    #1; chk("t5_cyc_drop", {bus.mem_cyc_o, bus.inst_ack_o, bus.bus_err_o}, 3'b000); tick("t5d");
    bus.mem_ack_i = 1;
    #1; chk("t5_tie_inst", bus.mem_adr_o, 13'h00AA); tick("t5e");
    bus.inst_cyc_i = 0; bus.inst_stb_i = 0; bus.mem_ack_i = 0;
    step("t5f");
    bus.mem_ack_i = 1;
    step("t5g");
    bus.data_cyc_i = 0; bus.data_stb_i = 0; bus.mem_ack_i = 0;
    step("t5h");

    // 6: aborts leave last_gnt alone; abort on the timeout cycle raises nothing
    bus.inst_cyc_i = 1; bus.inst_stb_i = 1; bus.inst_adr_i = 12'h246;
    step("t6a");
    step("t6b");
    bus.inst_cyc_i = 0; bus.inst_stb_i = 0; bus.data_cyc_i = 1; bus.data_stb_i = 1;
    #1; chk("t6_abort", {bus.mem_cyc_o, bus.inst_ack_o}, 2'b00); tick("t6c");
    bus.inst_cyc_i = 1; bus.inst_stb_i = 1;
    step("t6d");
    #1; chk("t6_tie_after_abort", bus.mem_adr_o, 13'h0246); tick("t6e");
    for (int k = 2; k < TIMEOUT; k++) step("t6_w");
    bus.inst_cyc_i = 0; bus.inst_stb_i = 0;
    #1; chk("t6_abort_at_to", {bus.inst_ack_o, bus.mem_cyc_o}, 2'b00); tick("t6f");
    #1; chk("t6_no_err", bus.bus_err_o, 1'b0); tick("t6g");
    bus.mem_ack_i = 1;
    step("t6h");
    bus.data_cyc_i = 0; bus.data_stb_i = 0; bus.mem_ack_i = 0;
    step("t6i");

    // randomized traffic with alternating responsive / sluggish memory
    p = 40;
    for (int n = 0; n < 3000; n++) begin
      if (n % 400 == 0) p = ((n / 400) % 2 != 0) ? 4 : 40;
      rst = ($urandom % 600 == 0);
      if (prev_ack_i && ($urandom % 2 != 0)) bus.inst_cyc_i = 0;
      else if (!bus.inst_cyc_i) bus.inst_cyc_i = ($urandom % 4 == 0);
      else if ($urandom % 40 == 0) bus.inst_cyc_i = 0;
      if (prev_ack_d && ($urandom % 2 != 0)) bus.data_cyc_i = 0;
      else if (!bus.data_cyc_i) bus.data_cyc_i = ($urandom % 4 == 0);
      else if ($urandom % 40 == 0) bus.data_cyc_i = 0;
      bus.inst_stb_i = bus.inst_cyc_i && ($urandom % 6 != 0);
      bus.data_stb_i = bus.data_cyc_i && ($urandom % 6 != 0);
      bus.data_we_i  = ($urandom % 2 != 0);
      bus.inst_adr_i = 12'($urandom);
      bus.data_adr_i = 8'($urandom);
      bus.data_dat_i = 8'($urandom);
      bus.mem_dat_i  = 18'($urandom);
      bus.mem_ack_i  = ($urandom % 100) < p;
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
